// File: rtl/cmul_pkg.sv
`default_nettype none
// ============================================================================
// Module      : cmul_pkg
// Description : Shared types and constants for the complex multiplier
//               arbitration slice: FSM state encoding, default operand width
//               and field slots inside the packed operand/result vectors.
// Revision    : 1.0 - initial release
// ============================================================================
package cmul_pkg;

  // Arbiter FSM states
  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    ISSUE    = 2'd1,
    WAIT_RES = 2'd2,
    DELIVER  = 2'd3
  } state_t;

  // Default width of one signed operand component
  localparam int DEF_DATA_W = 8;

  // Field slots in {a_re,a_im,b_re,b_im}; bit offset = slot * DATA_W
  localparam int OP_A_RE = 3;
  localparam int OP_A_IM = 2;
  localparam int OP_B_RE = 1;
  localparam int OP_B_IM = 0;

  // Field slots in {p_re,p_im}; bit offset = slot * RES_W
  localparam int RES_P_RE = 1;
  localparam int RES_P_IM = 0;

endpackage
`default_nettype wire

// File: rtl/cmul_rr_pick.sv
`default_nettype none
// ============================================================================
// Module      : cmul_rr_pick
// Description : Combinational round-robin winner selection. Scans upward from
//               last_grant+1 with wrap-around and returns the first requester
//               whose valid bit is set.
// Revision    : 1.0 - initial release
// ============================================================================
module cmul_rr_pick #(
  parameter int NUM_REQ = 4,
  parameter int ID_W    = $clog2(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] val,
  input  logic [ID_W-1:0]    last_grant,
  output logic [ID_W-1:0]    winner,
  output logic               any_val
);

  // Index that lies 'step' positions after 'base', wrapping at NUM_REQ
  function automatic logic [ID_W-1:0] wrap_idx(input logic [ID_W-1:0] base,
                                               input int step);
    int s;
    s = int'(base) + step;
    if (s >= NUM_REQ) s = s - NUM_REQ;
    return ID_W'(s);
  endfunction

  // Scan from the farthest candidate down to the nearest so the nearest set bit wins
  always_comb begin
    winner  = '0;
    any_val = |val;
    for (int i = NUM_REQ; i >= 1; i--) begin
      if (val[wrap_idx(last_grant, i)]) winner = wrap_idx(last_grant, i);
    end
  end

endmodule
`default_nettype wire

// File: rtl/cmul_rr_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : cmul_rr_arbiter
// Description : Shares one non-pipelined complex multiplier core between
//               NUM_REQ requesters. Round-robin grant, operands latched from
//               the winner, issued to the core over valid/ready, result
//               captured and returned to the issuing requester. One operation
//               in flight at a time.
// Revision    : 1.0 - initial release
// ============================================================================
module cmul_rr_arbiter
  import cmul_pkg::*;
#(
  parameter int NUM_REQ = 4,
  parameter int DATA_W  = DEF_DATA_W,
  parameter int RES_W   = 2*DATA_W+1,
  parameter int ID_W    = $clog2(NUM_REQ)
) (
  input  logic                      clk,
  input  logic                      rstn,
  input  logic                      sw_rst,
  input  logic [NUM_REQ-1:0]        req_op_val,
  output logic [NUM_REQ-1:0]        req_op_rdy,
  input  logic [NUM_REQ*4*DATA_W-1:0] req_op_data,
  output logic [NUM_REQ-1:0]        req_res_val,
  input  logic [NUM_REQ-1:0]        req_res_rdy,
  output logic [2*RES_W-1:0]        req_res_data,
  output logic                      core_op_val,
  input  logic                      core_op_rdy,
  output logic [4*DATA_W-1:0]       core_op_data,
  input  logic                      core_res_val,
  output logic                      core_res_rdy,
  input  logic [2*RES_W-1:0]        core_res_data,
  output logic                      busy,
  output logic [ID_W-1:0]           grant_id
);

  localparam int OP_W = 4*DATA_W;

  state_t              state;
  state_t              state_nxt;
  logic [ID_W-1:0]     last_grant;
  logic [ID_W-1:0]     winner;
  logic                any_val;
  logic [NUM_REQ-1:0]  win_oh;
  logic [NUM_REQ-1:0]  grant_oh;
  logic [OP_W-1:0]     op_sel;
  logic [OP_W-1:0]     op_reg;
  logic [2*RES_W-1:0]  res_reg;
  logic                accept;
  logic                res_fire;
  logic                dlv_fire;

  cmul_rr_pick #(
    .NUM_REQ (NUM_REQ),
    .ID_W    (ID_W)
  ) u_pick (
    .val        (req_op_val),
    .last_grant (last_grant),
    .winner     (winner),
    .any_val    (any_val)
  );

  // Winner one-hot and its operand slice
  always_comb begin
    win_oh = '0;
    op_sel = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (winner == ID_W'(i)) begin
        win_oh[i] = 1'b1;
        op_sel    = req_op_data[i*OP_W +: OP_W];
      end
    end
  end

  // One-hot of the requester owning the current/last operation
  always_comb begin
    grant_oh = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (grant_id == ID_W'(i)) grant_oh[i] = 1'b1;
    end
  end

  // Next-state and handshake outputs
  always_comb begin
    state_nxt    = state;
    req_op_rdy   = '0;
    core_op_val  = 1'b0;
    core_res_rdy = 1'b0;
    req_res_val  = '0;
    accept       = 1'b0;
    res_fire     = 1'b0;
    dlv_fire     = 1'b0;
    case (state)
      IDLE: begin
        // A soft reset in this cycle would discard the latch, so do not
        // signal acceptance to the requester either
        if (any_val && !sw_rst) begin
          req_op_rdy = win_oh;
          accept     = 1'b1;
          state_nxt  = ISSUE;
        end
      end
      ISSUE: begin
        core_op_val = 1'b1;
        if (core_op_rdy) state_nxt = WAIT_RES;
      end
      WAIT_RES: begin
        core_res_rdy = 1'b1;
        if (core_res_val) begin
          res_fire  = 1'b1;
          state_nxt = DELIVER;
        end
      end
      DELIVER: begin
        req_res_val = grant_oh;
        if (|(grant_oh & req_res_rdy)) begin
          dlv_fire  = 1'b1;
          state_nxt = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  // State register; soft reset overrides any transition
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state <= IDLE;
    end else if (sw_rst) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Operand/result latches, grant index and round-robin pointer
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      last_grant <= ID_W'(NUM_REQ-1);
      grant_id   <= '0;
      op_reg     <= '0;
      res_reg    <= '0;
    end else if (sw_rst) begin
      last_grant <= ID_W'(NUM_REQ-1);
      grant_id   <= '0;
      op_reg     <= '0;
      res_reg    <= '0;
    end else begin
      if (accept) begin
        op_reg   <= op_sel;
        grant_id <= winner;
      end
      if (res_fire) res_reg    <= core_res_data;
      if (dlv_fire) last_grant <= grant_id;
    end
  end

  assign core_op_data = op_reg;
  assign req_res_data = res_reg;
  assign busy         = (state != IDLE);

endmodule
`default_nettype wire

// File: doc/cmul_rr_arbiter.md
Name: cmul_rr_arbiter

Overview:
Shares one non-pipelined complex multiplier core between NUM_REQ requesters.
- Round-robin arbitration; one operation in flight at a time.
- Operands are latched from the winning requester and issued to the core over a valid/ready handshake.
- The core result is captured and returned to the requester that issued the operation.
- Sits between the requester-side interconnect and the complex multiplier top.

Parameters:
NUM_REQ, 4, number of requesters (2..8).
DATA_W, 8, width of each signed operand component (re or im).
RES_W, 2*DATA_W+1, width of each signed result component.
ID_W, $clog2(NUM_REQ), grant index width.

Ports:
clk  in  1  clock; all logic rising-edge.
rstn  in  1  asynchronous active-low reset.
sw_rst  in  1  synchronous soft reset, active high.
req_op_val  in  NUM_REQ  per-requester operand valid.
req_op_rdy  out  NUM_REQ  per-requester operand accept.
req_op_data  in  NUM_REQ*4*DATA_W  per requester {a_re,a_im,b_re,b_im}; requester 0 in the LSBs.
req_res_val  out  NUM_REQ  per-requester result valid.
req_res_rdy  in  NUM_REQ  per-requester result accept.
req_res_data  out  2*RES_W  shared result bus {p_re,p_im}.
core_op_val  out  1  operands valid to core.
core_op_rdy  in  1  core accepts operands.
core_op_data  out  4*DATA_W  latched operands.
core_res_val  in  1  core result valid.
core_res_rdy  out  1  arbiter accepts result.
core_res_data  in  2*RES_W  core result {p_re,p_im}.
busy  out  1  high in any state other than IDLE.
grant_id  out  ID_W  index of the current/last granted requester.

Behaviour:
- Reset values (rstn low, async; or sw_rst high at a clock edge):
  - state=IDLE; last_grant=NUM_REQ-1, so requester 0 has top priority.
  - grant_id=0; op_reg=0; res_reg=0.
  - core_op_val=0, core_res_rdy=0, req_res_val=0, busy=0.
- States:
  - IDLE: if any req_op_val, winner = first set bit scanning last_grant+1 upward with wrap. req_op_rdy[winner]=1 in that cycle only. At the edge: latch that requester's operands into op_reg, grant_id<=winner, go to ISSUE. Else stay.
  - ISSUE: core_op_val=1, core_op_data=op_reg. On core_op_rdy go to WAIT_RES.
  - WAIT_RES: core_res_rdy=1. On core_res_val latch core_res_data into res_reg and go to DELIVER.
  - DELIVER: req_res_val[grant_id]=1, req_res_data=res_reg. On req_res_rdy[grant_id]: last_grant<=grant_id, go to IDLE.
- Signal scope:
  - req_op_rdy is 0 outside IDLE.
  - core_res_rdy is 0 outside WAIT_RES, so a core result arriving in any other state is ignored.
  - req_res_data holds res_reg at all times; it is meaningful only while req_res_val is high.
- Latency: accept at cycle T, core_op_val at T+1. Result delivered 1 cycle after core_res_val. Minimum 1 IDLE cycle between consecutive grants.
- Stability: op_reg, res_reg and grant_id change only on the transitions above. Data stays stable under backpressure on either side.
- Protocol rules:
  - A requester holds req_op_val and its data until req_op_rdy; the arbiter does not check this.
  - Deasserting req_op_val early only affects arbitration in the next IDLE cycle.
- Fairness: after requester k is served, k has the lowest priority. With all requesters valid, grants cycle 0,1,..,NUM_REQ-1,0.
- sw_rst mid-operation: abandons the in-flight operation; no req_res_val is produced. The core receives the same sw_rst. sw_rst has priority over every transition in the same cycle.
- rstn low: outputs take reset values immediately, without a clock edge.

Decomposition:
- Shared package cmul_pkg:
  - state encodings IDLE/ISSUE/WAIT_RES/DELIVER (2-bit);
  - default DATA_W;
  - operand/result field offsets for packing {a_re,a_im,b_re,b_im} and {p_re,p_im}.
- Sub-module cmul_rr_pick: combinational round-robin winner. Inputs: val vector and last_grant. Outputs: winner index and any_val. Reusable by other shared-resource controllers.

Test Plan:
- Single request: req1 sends (3+2j)*(1+4j), i.e. {3,2,1,4}; core_op_data={3,2,1,4} at T+1; core returns {-5,14}. Then req_res_val=4'b0010 with req_res_data={-5,14}, grant_id=1, and busy drops after req_res_rdy[1].
- All four requesters held valid with core and sinks always ready: grant order 0,1,2,3,0,1; each req_op_rdy pulses exactly once per grant.
- Backpressure:
  - core_op_rdy low 5 cycles: state stays ISSUE, core_op_data constant.
  - req_res_rdy[2] low 3 cycles: req_res_val[2] held, data constant, no new grant.
- sw_rst pulse in WAIT_RES, then core_res_val: arbiter in IDLE, core_res_rdy=0, no req_res_val. With req0 and req3 valid next, req0 wins (priority reset).
- rstn asserted asynchronously mid-DELIVER: req_res_val and busy go 0 before the next clock edge. After release the arbiter resumes from IDLE.
- After serving req2 with req0 and req2 valid: req0 is granted next (wrap 3→0); req2 waits one full round.
